tmvp_result_packer: RTL and testbench

//  Consumer stage placed directly after MainMultiplier, on its m_axis_tdata/m_axis_tvalid result stream.
//  - Accepts N wide accumulated TMVP coefficients, one per valid cycle. The input has no backpressure.
//  - Reduces each coefficient mod 2^DATA_WIDTH and packs PACK reduced coefficients into one word.
//  - Buffers the words in a FIFO and presents them on an AXI-Stream master with tready and tlast.

---
 rtl/tmvp_pkg.sv | 19 +
 rtl/tmvp_sync_fifo.sv | 52 +++++
 rtl/tmvp_result_packer.sv | 105 ++++++++++
 tb/tb_tmvp_result_packer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmvp_pkg.sv
// Shared sizing, state encoding and coefficient reduction for the TMVP result packer.
// The input width leaves room for the full accumulation growth of an N-term product.
package tmvp_pkg;
  localparam int N          = 864;
  localparam int DATA_WIDTH = 4;
  localparam int PACK       = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int IN_WIDTH   = 2*DATA_WIDTH + $clog2(N);
  localparam int CNT_W      = $clog2(N);
  localparam int LANE_W     = $clog2(PACK);
  localparam int WORD_W     = PACK*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Reduction mod 2^DATA_WIDTH is plain truncation of the accumulator.
  function automatic logic [DATA_WIDTH-1:0] reduce_coef(input logic [IN_WIDTH-1:0] c);
    return DATA_WIDTH'(c);
  endfunction
endpackage

// File: rtl/tmvp_sync_fifo.sv
// Synchronous FIFO; the head entry is visible the cycle after it is written.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module tmvp_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty entries read as zero so the stream data is clean outside of valid beats.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/tmvp_result_packer.sv
// Packs reduced TMVP coefficients PACK per word into a FIFO feeding an AXI-Stream master.
// tvalid follows a push by one cycle; input has no backpressure, words hitting a full FIFO set overflow.
module tmvp_result_packer
  import tmvp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] word;
  logic [WORD_W:0]   fifo_dat;
  logic              accept;
  logic              push;
  logic              pop;
  logic              last_coef;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept        = (state == RUN) && s_tvalid;
  assign last_coef     = (cnt == CNT_W'(N-1));
  assign push          = accept && (lane == LANE_W'(PACK-1));
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dat[WORD_W-1:0];
  assign m_axis_tlast  = fifo_dat[WORD_W];

  // The completing lane is merged combinationally so the push needs no extra cycle.
  always_comb begin
    word = pack_reg;
    word[lane*DATA_WIDTH +: DATA_WIDTH] = reduce_coef(s_tdata);
  end

  tmvp_sync_fifo #(.WIDTH(WORD_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat ({last_coef, word}),
    .pop      (pop),
    .flush    (start),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lane     <= '0;
      pack_reg <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      // Counting continues past dropped words so lane alignment and tlast stay correct.
      if (accept) begin
        cnt <= last_coef ? '0 : cnt + CNT_W'(1);
        if (lane == LANE_W'(PACK-1)) begin
          lane     <= '0;
          pack_reg <= '0;
        end else begin
          lane     <= lane + LANE_W'(1);
          pack_reg <= word;
        end
      end
      case (state)
        RUN:     if (accept && last_coef) state <= FLUSH;
        FLUSH: begin
          if (pop && m_axis_tlast) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: ;
      endcase
      // Start from any state re-arms the frame; an in-flight frame is aborted silently.
      if (start) begin
        state    <= RUN;
        busy     <= 1'b1;
        done     <= 1'b0;
        cnt      <= '0;
        lane     <= '0;
        pack_reg <= '0;
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tmvp_result_packer.sv
module tb_tmvp_result_packer;
  import tmvp_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [IN_WIDTH-1:0] s_tdata;
  logic                s_tvalid;
  logic [WORD_W-1:0]   m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic                busy;
  logic                done;
  logic                overflow;

  always #5 clk = ~clk;

  tmvp_result_packer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame phase, coefficients seen, partially built word, expected FIFO contents.
  typedef enum {M_IDLE, M_RUN, M_FLUSH, M_DONE} mstate_t;
  mstate_t           m_state;
  logic [WORD_W:0]   q[$];
  logic [WORD_W-1:0] mw;
  int                mk;
  bit                m_ovf;
  bit                m_done;

  int                beats;
  int                tlast_at;
  int                done_cnt;
  logic [WORD_W-1:0] first_beat;
  logic [WORD_W-1:0] exp_first;
  logic [IN_WIDTH-1:0] d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mw      = '0;
    mk      = 0;
    m_ovf   = 1'b0;
    m_done  = 1'b0;
    m_state = M_IDLE;
  endtask

  task automatic clear_stats();
    beats      = 0;
    tlast_at   = 0;
    done_cnt   = 0;
    first_beat = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tvalid"},   32'(m_axis_tvalid), 0);
    chk({tag, "_tdata"},    32'(m_axis_tdata),  0);
    chk({tag, "_tlast"},    32'(m_axis_tlast),  0);
    chk({tag, "_busy"},     32'(busy),          0);
    chk({tag, "_done"},     32'(done),          0);
    chk({tag, "_overflow"}, 32'(overflow),      0);
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
  task automatic tick(input bit sv, input logic [IN_WIDTH-1:0] sd, input bit rdy, input bit st);
    bit              pop;
    logic [WORD_W:0] head;
    start         = st;
    s_tvalid      = sv;
    s_tdata       = sd;
    m_axis_tready = rdy;
    @(negedge clk);
    chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tdata", 32'(m_axis_tdata), 32'(q[0][WORD_W-1:0]));
      chk("tlast", 32'(m_axis_tlast), 32'(q[0][WORD_W]));
    end
    chk("busy", 32'(busy), 32'(m_state == M_RUN || m_state == M_FLUSH));
    chk("done", 32'(done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_axis_tvalid && m_axis_tready) begin
      beats++;
      if (beats == 1) first_beat = m_axis_tdata;
      if (m_axis_tlast) tlast_at = beats;
    end
    if (done) done_cnt++;

    pop    = (q.size() != 0) && rdy;
    m_done = 1'b0;
    head   = '0;
    if (pop) head = q.pop_front();
    if (st) begin
      q.delete();
      mw      = '0;
      mk      = 0;
      m_ovf   = 1'b0;
      m_state = M_RUN;
    end else begin
      case (m_state)
        M_RUN: if (sv) begin
          mw = mw | WORD_W'((32'(sd) % (1 << DATA_WIDTH)) << ((mk % PACK) * DATA_WIDTH));
          mk++;
          if (mk % PACK == 0) begin
            if (q.size() < FIFO_DEPTH) q.push_back({(mk == N), mw});
            else m_ovf = 1'b1;
            mw = '0;
          end
          if (mk == N) m_state = M_FLUSH;
        end
        M_FLUSH: if (pop && head[WORD_W]) begin
          m_state = M_DONE;
          m_done  = 1'b1;
        end
        M_DONE:  m_state = M_IDLE;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while (m_state != M_IDLE && n < budget) begin
      tick(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      n++;
    end
    chk("drain_reached_idle", 32'(m_state == M_IDLE), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_axis_tready = 1'b0;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, k*0x101, tready held high
    clear_stats();
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) tick(1'b1, IN_WIDTH'(k * 257), 1'b1, 1'b0);
    drain(200, 1'b0);
    chk("t1_beat0", 32'(first_beat), 32'h3210);
    chk("t1_beats", 32'(beats), N / PACK);
    chk("t1_tlast_at", 32'(tlast_at), N / PACK);
    chk("t1_done_cnt", 32'(done_cnt), 1);

    // Gapped input with random backpressure
    clear_stats();
    tick(1'b0, '0, 1'b1, 1'b1);
    begin
      int k = 0;
      int guard = 0;
      while (k < N && guard < 20000) begin
        bit v;
        v = 1'($urandom_range(0, 1));
        tick(v, IN_WIDTH'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        if (v) k++;
        guard++;
      end
      chk("t2_input_bound", 32'(k), N);
    end
    drain(5000, 1'b1);
    chk("t2_beats", 32'(beats), N / PACK);
    chk("t2_tlast_at", 32'(tlast_at), N / PACK);
    chk("t2_overflow", 32'(overflow), 0);
    chk("t2_done_cnt", 32'(done_cnt), 1);

    // Overflow: tready low for the whole frame
    clear_stats();
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) tick(1'b1, IN_WIDTH'($urandom()), 1'b0, 1'b0);
    chk("t3_overflow", 32'(overflow), 1);
    for (int i = 0; i < 40; i++) tick(1'b0, '0, 1'b1, 1'b0);
    chk("t3_beats", 32'(beats), FIFO_DEPTH);
    chk("t3_tlast_at", 32'(tlast_at), 0);
    chk("t3_done_cnt", 32'(done_cnt), 0);
    chk("t3_overflow_sticky", 32'(overflow), 1);

    // Restart after 100 coefficients
    clear_stats();
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 100; k++) tick(1'b1, IN_WIDTH'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
    tick(1'b1, IN_WIDTH'($urandom()), 1'b0, 1'b1);
    chk("t4_fifo_empty", 32'(m_axis_tvalid), 0);
    chk("t4_abort_no_done", 32'(done_cnt), 0);
    clear_stats();
    exp_first = '0;
    for (int k = 0; k < N; k++) begin
      d = IN_WIDTH'($urandom());
      if (k < PACK) exp_first = exp_first | WORD_W'((32'(d) % 16) << (4 * k));
      tick(1'b1, d, 1'b1, 1'b0);
    end
    drain(200, 1'b0);
    chk("t4_beat0", 32'(first_beat), 32'(exp_first));
    chk("t4_beats", 32'(beats), N / PACK);
    chk("t4_done_cnt", 32'(done_cnt), 1);

    // Asynchronous reset in the middle of a frame
    clear_stats();
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 50; k++) tick(1'b1, IN_WIDTH'(k * 257), 1'b1, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t5_async");
    model_reset();
    start = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fresh frame after reset; first four coefficients all ones
    clear_stats();
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) tick(1'b1, (k < PACK) ? '1 : IN_WIDTH'(k * 257), 1'b1, 1'b0);
    drain(200, 1'b0);
    chk("t6_beat0_wide", 32'(first_beat), 32'hFFFF);
    chk("t6_beats", 32'(beats), N / PACK);
    chk("t6_tlast_at", 32'(tlast_at), N / PACK);
    chk("t6_done_cnt", 32'(done_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
